// File: rtl/pcpi_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : pcpi_initiator
//  Purpose  : Issuing side of the PCPI coprocessor interface. Takes one
//             command on a valid/ready port, drives the PCPI request, waits
//             for a coprocessor to finish (or aborts on no-taker/watchdog),
//             and returns the result on a valid/ready response port.
//  Revision : 1.0  initial release
// ============================================================================
module pcpi_initiator #(
  parameter int TIMEOUT  = 16,
  parameter int WATCHDOG = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_wr,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0]  ST_OK       = 2'b00;
  localparam logic [1:0]  ST_NOTAKER  = 2'b01;
  localparam logic [1:0]  ST_WATCHDOG = 2'b10;
  // Counter values at which "count+1 == limit" holds; avoids a wider adder.
  localparam logic [7:0]  TO_LAST     = 8'(TIMEOUT - 1);
  localparam logic [15:0] WD_LAST     = 16'((WATCHDOG == 0) ? 0 : WATCHDOG - 1);
  localparam logic        WD_EN       = (WATCHDOG != 0);

  state_t      state, state_nxt;
  logic [7:0]  nowait_cnt, nowait_cnt_nxt;
  logic [15:0] total_cnt, total_cnt_nxt;

  logic        cmd_ready_nxt, rsp_valid_nxt, rsp_wr_nxt, busy_nxt, pcpi_valid_nxt;
  logic [31:0] rsp_rd_nxt, pcpi_insn_nxt, pcpi_rs1_nxt, pcpi_rs2_nxt;
  logic [1:0]  rsp_status_nxt;
  logic        finish;

  // State, counters and every output are registered here; reset drops any
  // in-flight command without producing a response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      nowait_cnt <= '0;
      total_cnt  <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rd     <= '0;
      rsp_wr     <= 1'b0;
      rsp_status <= '0;
      busy       <= 1'b0;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
    end else begin
      state      <= state_nxt;
      nowait_cnt <= nowait_cnt_nxt;
      total_cnt  <= total_cnt_nxt;
      cmd_ready  <= cmd_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rd     <= rsp_rd_nxt;
      rsp_wr     <= rsp_wr_nxt;
      rsp_status <= rsp_status_nxt;
      busy       <= busy_nxt;
      pcpi_valid <= pcpi_valid_nxt;
      pcpi_insn  <= pcpi_insn_nxt;
      pcpi_rs1   <= pcpi_rs1_nxt;
      pcpi_rs2   <= pcpi_rs2_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_nxt      = state;
    nowait_cnt_nxt = nowait_cnt;
    total_cnt_nxt  = total_cnt;
    cmd_ready_nxt  = cmd_ready;
    rsp_valid_nxt  = rsp_valid;
    rsp_rd_nxt     = rsp_rd;
    rsp_wr_nxt     = rsp_wr;
    rsp_status_nxt = rsp_status;
    busy_nxt       = busy;
    pcpi_valid_nxt = pcpi_valid;
    pcpi_insn_nxt  = pcpi_insn;
    pcpi_rs1_nxt   = pcpi_rs1;
    pcpi_rs2_nxt   = pcpi_rs2;
    finish         = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready_nxt  = 1'b1;
        nowait_cnt_nxt = '0;
        total_cnt_nxt  = '0;
        if (cmd_valid && cmd_ready) begin
          pcpi_insn_nxt  = cmd_insn;
          pcpi_rs1_nxt   = cmd_rs1;
          pcpi_rs2_nxt   = cmd_rs2;
          pcpi_valid_nxt = 1'b1;
          cmd_ready_nxt  = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = ISSUE;
        end
      end

      ISSUE: begin
        // Completion beats both aborts; the watchdog beats the no-taker check.
        if (pcpi_ready) begin
          finish         = 1'b1;
          rsp_rd_nxt     = pcpi_wr ? pcpi_rd : 32'd0;
          rsp_wr_nxt     = pcpi_wr;
          rsp_status_nxt = ST_OK;
        end else if (WD_EN && (total_cnt == WD_LAST)) begin
          finish         = 1'b1;
          rsp_rd_nxt     = '0;
          rsp_wr_nxt     = 1'b0;
          rsp_status_nxt = ST_WATCHDOG;
        end else if (!pcpi_wait && (nowait_cnt == TO_LAST)) begin
          finish         = 1'b1;
          rsp_rd_nxt     = '0;
          rsp_wr_nxt     = 1'b0;
          rsp_status_nxt = ST_NOTAKER;
        end else begin
          total_cnt_nxt  = total_cnt + 16'd1;
          nowait_cnt_nxt = pcpi_wait ? 8'd0 : nowait_cnt + 8'd1;
        end
        if (finish) begin
          pcpi_valid_nxt = 1'b0;
          rsp_valid_nxt  = 1'b1;
          state_nxt      = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pcpi_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcpi_initiator
//  Purpose  : Directed self-checking bench for pcpi_initiator with a small
//             behavioural coprocessor model (multiplier / staller / late-ready).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcpi_initiator;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_insn = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rd;
  logic        rsp_wr;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        pcpi_wait = 1'b0;
  logic        pcpi_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // Coprocessor model mode: 0 none, 1 multiplier, 2 claim forever, 3 late ready
  int mode = 0;
  int vcnt = 0;

  pcpi_initiator #(.TIMEOUT(16), .WATCHDOG(100)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_status(rsp_status),
    .busy(busy),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );

  always #5 clk = ~clk;

  // Coprocessor model: counts cycles of pcpi_valid and answers on negedges.
  always @(negedge clk) begin
    logic [63:0] prod;
    vcnt = pcpi_valid ? vcnt + 1 : 0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    if (vcnt > 0) begin
      case (mode)
        1: begin
          prod = {32'd0, pcpi_rs1} * {32'd0, pcpi_rs2};
          if (vcnt < 3) pcpi_wait = 1'b1;
          if (vcnt == 3) begin
            pcpi_ready = 1'b1;
            pcpi_wr    = 1'b1;
            pcpi_rd    = (pcpi_insn[14:12] == 3'd3) ? prod[63:32] : prod[31:0];
          end
        end
        2: pcpi_wait = 1'b1;
        3: if (vcnt == 16) begin
          pcpi_ready = 1'b1;
          pcpi_wr    = 1'b1;
          pcpi_rd    = 32'hDEADBEEF;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one command at a negedge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_insn = insn; cmd_rs1 = a; cmd_rs2 = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Counts edges until rsp_valid rises (bounded).
  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 300) begin @(posedge clk); #1; cycles++; end
    check("rsp_valid_within_bound", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic consume;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    check("busy_after_hs", {31'd0, busy}, 32'd0);
    check("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    // Reset state
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("cmd_ready_first_cycle", {31'd0, cmd_ready}, 32'd1);

    // 1: MUL 7*6
    mode = 1;
    send(32'h02B50533, 32'd7, 32'd6);
    check("t1_pcpi_valid", {31'd0, pcpi_valid}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    wait_rsp(cyc);
    check("t1_latency", cyc, 32'd3);
    check("t1_pcpi_valid_drop", {31'd0, pcpi_valid}, 32'd0);
    check("t1_status", {30'd0, rsp_status}, 32'd0);
    check("t1_wr", {31'd0, rsp_wr}, 32'd1);
    check("t1_rd", rsp_rd, 32'd42);
    consume();

    // 2: MULHU all-ones
    send(32'h02B53533, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_rsp(cyc);
    check("t2_status", {30'd0, rsp_status}, 32'd0);
    check("t2_rd", rsp_rd, 32'hFFFFFFFE);
    consume();
    check("t2_insn_held", pcpi_insn, 32'h02B53533);

    // 3: no taker
    mode = 0;
    send(32'h0000000B, 32'd1, 32'd2);
    wait_rsp(cyc);
    check("t3_valid_cycles", cyc, 32'd16);
    check("t3_status", {30'd0, rsp_status}, 32'd1);
    check("t3_rd", rsp_rd, 32'd0);
    check("t3_wr", {31'd0, rsp_wr}, 32'd0);
    consume();

    // 4: watchdog with coprocessor stalling forever
    mode = 2;
    send(32'h0000002B, 32'd3, 32'd4);
    wait_rsp(cyc);
    check("t4_issue_cycles", cyc, 32'd100);
    check("t4_status", {30'd0, rsp_status}, 32'd2);
    check("t4_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
    check("t4_rd", rsp_rd, 32'd0);
    consume();

    // 5: ready coincides with the 16th no-wait cycle, then backpressure
    mode = 3;
    send(32'h0000005B, 32'd5, 32'd6);
    wait_rsp(cyc);
    check("t5_cycles", cyc, 32'd16);
    check("t5_status", {30'd0, rsp_status}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("t5_hold_rd", rsp_rd, 32'hDEADBEEF);
      check("t5_hold_status", {30'd0, rsp_status}, 32'd0);
      check("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("t5_hold_busy", {31'd0, busy}, 32'd1);
    end
    consume();

    // 6: asynchronous reset mid-ISSUE
    mode = 2;
    send(32'h0000007B, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("t6_pcpi_valid_async", {31'd0, pcpi_valid}, 32'd0);
    check("t6_rsp_valid_async", {31'd0, rsp_valid}, 32'd0);
    check("t6_busy_async", {31'd0, busy}, 32'd0);
    mode = 1;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("t6_cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    check("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(32'h02B50533, 32'd3, 32'd5);
    wait_rsp(cyc);
    check("t6_status", {30'd0, rsp_status}, 32'd0);
    check("t6_rd", rsp_rd, 32'd15);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
